fifo_sr_wr_arbiter: RTL and testbench
=====================================

Name: fifo_sr_wr_arbiter

Overview:
Write-side arbiter and credit controller for the shared-memory multi-flux FIFO. Up to FLUX producers each present a tagged-by-position request. The block shares the FIFO's single write port among them with round-robin fairness and a per-flux occupancy quota, so no flux can starve the others of shared locations. It drives the FIFO write port through a one-cycle register stage and tracks per-flux occupancy from the FIFO's one-hot read vector, so it never issues a write into a full memory.

Parameters:
DATA_WIDTH, 8, payload width per producer
DEPTH, 4, shared FIFO depth; must match the FIFO instance
FLUX, 2, number of producers/fluxes; FLUX >= 2
QUOTA, 2, max locations one flux may hold (written plus in flight); 1 <= QUOTA <= DEPTH
TAG_WIDTH (local), $clog2(FLUX)
CNT_WIDTH (local), $clog2(DEPTH)+1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high
req_valid  in  FLUX  per-producer request
req_data  in  FLUX*DATA_WIDTH  producer i payload at slice [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  FLUX  grant; at most one bit high; transfer when req_valid[i] & req_ready[i]
fifo_din  out  DATA_WIDTH+TAG_WIDTH  {tag, payload} to FIFO write port; tag in MSBs
fifo_write  out  1  FIFO write strobe
fifo_full  in  1  FIFO full flag; used only for error checking
fifo_read  in  FLUX  copy of FIFO one-hot read vector (consumer side)
occ_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: req_ready=0, fifo_write=0, fifo_din=0, occ_err=0, all cnt[i]=0, rr_ptr=FLUX-1, so flux 0 has first priority. A mid-operation reset discards any pending write. The FIFO must be reset in the same cycle.
- State per flux: cnt[i] (CNT_WIDTH bits) = locations held by flux i, including a write registered but not yet performed. tot = sum of cnt[i], computed combinationally.
- Eligibility: elig[i] = req_valid[i] & (cnt[i] < QUOTA) & (tot < DEPTH).
- Arbitration (combinational, same cycle as request): search elig starting at (rr_ptr+1) mod FLUX, wrapping; the first hit g gets req_ready[g]=1. If no flux is eligible, req_ready=0. req_ready never depends on fifo_full.
- On a grant edge: rr_ptr<=g; fifo_din<={g[TAG_WIDTH-1:0], req_data[g]}; fifo_write<=1. Without a grant: fifo_write<=0, fifo_din holds its value, rr_ptr holds.
- Latency: grant in cycle N gives fifo_write=1 in cycle N+1. One write per cycle maximum, back-to-back allowed.
- Counter update per flux i each edge: +1 if granted, -1 if fifo_read[i] & cnt[i]!=0. A grant and a read on the same flux in one cycle give net 0. A grant on flux i and a read on flux j update both counters.
- Read freeing space: a read in cycle N does not lower tot until N+1, so the freed slot is grantable from N+1. There is no same-cycle pass-through.
- Errors (occ_err set, sticky until rst):
  - fifo_read[i]=1 while cnt[i]==0; cnt[i] stays 0.
  - fifo_read not one-hot or zero.
  - fifo_write=1 while fifo_full=1.
- Boundary conditions:
  - tot==DEPTH: no grants.
  - cnt[i]==QUOTA: flux i is skipped, and the pointer passes to the next eligible flux.
  - QUOTA=DEPTH disables per-flux limiting.
  - A single active requester is granted every cycle while eligible.
- Widths: cnt saturates nowhere by construction (cnt <= QUOTA <= DEPTH). tot is CNT_WIDTH bits and cannot exceed DEPTH.

Test Plan:
- Reset, then req_valid=2'b11 held, no reads, DEPTH=4, QUOTA=2 -> grants 0,1,0,1; fifo_din tags 0,1,0,1 one cycle later; then req_ready=0 with cnt={2,2} and occ_err=0.
- Only flux 0 requesting, QUOTA=2 -> two grants, then stall. Pulse fifo_read=2'b01 in cycle N -> new grant to flux 0 in cycle N+1 and not in N.
- Fill to cnt={2,1}, then in the same cycle grant flux 1 and fifo_read=2'b10 -> cnt[1] stays 1 and tot stays 3.
- QUOTA=4, flux 0 fills all 4 locations -> flux 1 is blocked while req_valid[1]=1. One read on flux 0 -> flux 1 is granted the next cycle (round-robin priority after 0).
- fifo_read=2'b10 with cnt[1]=0 -> occ_err=1 and stays 1 until rst, and cnt unchanged. Separately, fifo_read=2'b11 -> occ_err=1.
- Assert rst while fifo_write=1 is pending -> next cycle fifo_write=0, req_ready=0, all cnt=0, and the first grant after reset goes to flux 0.

Source files
------------

// File: rtl/fifo_sr_wr_arbiter.sv
// Write-side arbiter and credit controller for the shared-memory multi-flux FIFO.
// Round-robin grant among producers, per-flux occupancy quota, one-cycle
// registered write stage, and occupancy tracking from the FIFO read vector.
module fifo_sr_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  parameter  int FLUX       = 2,
  parameter  int QUOTA      = 2,
  localparam int TAG_WIDTH  = $clog2(FLUX),
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FLUX-1:0]                 req_valid,
  input  logic [FLUX*DATA_WIDTH-1:0]      req_data,
  output logic [FLUX-1:0]                 req_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_din,
  output logic                            fifo_write,
  input  logic                            fifo_full,
  input  logic [FLUX-1:0]                 fifo_read,
  output logic                            occ_err
);

  logic [CNT_WIDTH-1:0]            cnt_q [FLUX];
  logic [CNT_WIDTH-1:0]            cnt_d [FLUX];
  logic [TAG_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_din_q, fifo_din_d;
  logic                            fifo_write_q, fifo_write_d;
  logic                            occ_err_q, occ_err_d;

  logic [CNT_WIDTH-1:0]  tot;
  logic [FLUX-1:0]       elig;
  logic [FLUX-1:0]       grant;
  logic                  gnt_vld;
  logic [TAG_WIDTH-1:0]  gnt_idx;
  logic [DATA_WIDTH-1:0] payload [FLUX];

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_payload
    assign payload[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Total locations held (written or in flight) across all fluxes.
  always_comb begin
    tot = '0;
    for (int i = 0; i < FLUX; i++) begin
      tot = tot + cnt_q[i];
    end
  end

  // A flux may be granted only below its quota and while the memory has room;
  // nothing is granted during reset so the pending-write stage stays empty.
  always_comb begin
    elig = '0;
    for (int i = 0; i < FLUX; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_WIDTH'(QUOTA)) &&
                (tot < CNT_WIDTH'(DEPTH)) && !rst;
    end
  end

  // Round-robin search starting just after the last granted flux.
  always_comb begin
    logic [TAG_WIDTH-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    cand    = '0;
    for (int k = 1; k <= FLUX; k++) begin
      cand = TAG_WIDTH'((int'(rr_ptr_q) + k) % FLUX);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  // Next-state: counters, pointer, write stage and sticky error detection.
  always_comb begin
    logic dec;
    occ_err_d    = occ_err_q;
    rr_ptr_d     = rr_ptr_q;
    fifo_din_d   = fifo_din_q;
    fifo_write_d = 1'b0;
    dec          = 1'b0;

    if ((fifo_read & (fifo_read - FLUX'(1))) != '0) occ_err_d = 1'b1;
    if (fifo_write_q && fifo_full)                   occ_err_d = 1'b1;

    for (int i = 0; i < FLUX; i++) begin
      dec = fifo_read[i] && (cnt_q[i] != '0);
      if (fifo_read[i] && (cnt_q[i] == '0)) occ_err_d = 1'b1;
      cnt_d[i] = cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, grant[i]}
                          - {{(CNT_WIDTH-1){1'b0}}, dec};
    end

    if (gnt_vld) begin
      rr_ptr_d     = gnt_idx;
      fifo_din_d   = {gnt_idx, payload[gnt_idx]};
      fifo_write_d = 1'b1;
    end
  end

  // State registers with synchronous reset; flux 0 gets first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) cnt_q[i] <= '0;
      rr_ptr_q     <= TAG_WIDTH'(FLUX - 1);
      fifo_din_q   <= '0;
      fifo_write_q <= 1'b0;
      occ_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_din_q   <= fifo_din_d;
      fifo_write_q <= fifo_write_d;
      occ_err_q    <= occ_err_d;
    end
  end

  assign req_ready  = grant;
  assign fifo_din   = fifo_din_q;
  assign fifo_write = fifo_write_q;
  assign occ_err    = occ_err_q;

endmodule

// File: tb/tb_fifo_sr_wr_arbiter.sv
// Bench for fifo_sr_wr_arbiter: two instances (quota 2 and quota 4) share the
// same stimulus and are compared every cycle against a queue-based model of
// the shared memory contents.
module tb_fifo_sr_wr_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FLUX  = 2;
  localparam int QA    = 2;
  localparam int QB    = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  fifo_read;
  logic        fifo_full;

  logic [1:0]  ready_a, ready_b;
  logic [8:0]  din_a, din_b;
  logic        wr_a, wr_b, err_a, err_b;

  logic [1:0]  obs_ready_a, obs_ready_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per instance, the tags of every held location in arrival order.
  int         mq[2][$];
  int         m_ptr[2];
  logic [8:0] m_din[2];
  bit         m_wr[2];
  bit         m_err[2];

  fifo_sr_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX), .QUOTA(QA)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .fifo_din(din_a), .fifo_write(wr_a),
    .fifo_full(fifo_full), .fifo_read(fifo_read), .occ_err(err_a));

  fifo_sr_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX), .QUOTA(QB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .fifo_din(din_b), .fifo_write(wr_b),
    .fifo_full(fifo_full), .fifo_read(fifo_read), .occ_err(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [1:0] v, input int f);
    return ((v >> f) & 2'b01) != 2'b00;
  endfunction

  function automatic int quota(input int k);
    return (k == 0) ? QA : QB;
  endfunction

  function automatic int mcnt(input int k, input int f);
    int c = 0;
    foreach (mq[k][j]) if (mq[k][j] == f) c++;
    return c;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_ptr[k] = FLUX - 1;
      m_din[k] = '0;
      m_wr[k]  = 1'b0;
      m_err[k] = 1'b0;
    end
  endfunction

  // One clock cycle with the currently driven inputs.
  task automatic step();
    int g[2];
    int f;
    bit e;
    logic [7:0] pay;
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k] = -1;
      if (!rst) begin
        for (int off = 1; off <= FLUX; off++) begin
          f = (m_ptr[k] + off) % FLUX;
          if (g[k] < 0 && bit_of(req_valid, f) && mcnt(k, f) < quota(k) &&
              mq[k].size() < DEPTH)
            g[k] = f;
        end
      end
    end
    obs_ready_a = ready_a;
    obs_ready_b = ready_b;
    check_eq("ready_a", 32'(ready_a), (g[0] < 0) ? 32'd0 : (32'd1 << g[0]));
    check_eq("ready_b", 32'(ready_b), (g[1] < 0) ? 32'd0 : (32'd1 << g[1]));

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = ($countones(fifo_read) > 1) || (m_wr[k] && fifo_full);
        for (int rf = 0; rf < FLUX; rf++) begin
          if (bit_of(fifo_read, rf)) begin
            if (mcnt(k, rf) == 0) e = 1'b1;
            else begin
              for (int j = 0; j < mq[k].size(); j++)
                if (mq[k][j] == rf) begin
                  mq[k].delete(j);
                  break;
                end
            end
          end
        end
        if (g[k] >= 0) begin
          mq[k].push_back(g[k]);
          m_ptr[k] = g[k];
          pay      = 8'(req_data >> (g[k] * DW));
          m_din[k] = {1'(g[k]), pay};
          m_wr[k]  = 1'b1;
        end else begin
          m_wr[k] = 1'b0;
        end
        if (e) m_err[k] = 1'b1;
      end
    end
    #1;
    check_eq("wr_a",  32'(wr_a),  32'(m_wr[0]));
    check_eq("wr_b",  32'(wr_b),  32'(m_wr[1]));
    check_eq("din_a", 32'(din_a), 32'(m_din[0]));
    check_eq("din_b", 32'(din_b), 32'(m_din[1]));
    check_eq("err_a", 32'(err_a), 32'(m_err[0]));
    check_eq("err_b", 32'(err_b), 32'(m_err[1]));
    @(negedge clk);
  endtask

  task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] rd, input logic full);
    rst       = r;
    req_valid = v;
    fifo_read = rd;
    fifo_full = full;
    req_data  = 16'($urandom);
    step();
  endtask

  logic [1:0] exp_p1 [5];
  logic [1:0] rd;
  int         pick;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_read = '0; fifo_full = 1'b0;
    model_reset();
    cyc(1, 2'b00, 2'b00, 0);
    check_eq("reset_wr_a",  32'(wr_a),  32'd0);
    check_eq("reset_din_a", 32'(din_a), 32'd0);
    check_eq("reset_err_a", 32'(err_a), 32'd0);

    // Both requesting: alternate until the memory is full.
    exp_p1 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b11, 2'b00, 0);
      check_eq("p1_grant", 32'(obs_ready_a), 32'(exp_p1[i]));
      if (i < 4) check_eq("p1_tag", 32'(din_a[8]), 32'(i % 2));
    end
    check_eq("p1_err", 32'(err_a), 32'd0);

    // Single requester hits its quota; a read frees a slot for the next cycle.
    cyc(1, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 2'b00, 0); check_eq("p2_g0", 32'(obs_ready_a), 32'd1);
    cyc(0, 2'b01, 2'b00, 0); check_eq("p2_g1", 32'(obs_ready_a), 32'd1);
    cyc(0, 2'b01, 2'b00, 0); check_eq("p2_stall", 32'(obs_ready_a), 32'd0);
    cyc(0, 2'b01, 2'b01, 0); check_eq("p2_read_cycle", 32'(obs_ready_a), 32'd0);
    cyc(0, 2'b01, 2'b00, 0); check_eq("p2_after_read", 32'(obs_ready_a), 32'd1);

    // Grant and read on the same flux in one cycle leave its count unchanged.
    cyc(1, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 2'b00, 0);
    cyc(0, 2'b01, 2'b00, 0);
    cyc(0, 2'b10, 2'b00, 0); check_eq("p3_fill", 32'(obs_ready_a), 32'd2);
    cyc(0, 2'b10, 2'b10, 0); check_eq("p3_same", 32'(obs_ready_a), 32'd2);
    cyc(0, 2'b10, 2'b00, 0); check_eq("p3_next", 32'(obs_ready_a), 32'd2);
    cyc(0, 2'b10, 2'b00, 0); check_eq("p3_full", 32'(obs_ready_a), 32'd0);

    // Quota equal to depth: one flux may fill the whole memory.
    cyc(1, 2'b00, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b01, 2'b00, 0);
      check_eq("p4_fill_b", 32'(obs_ready_b), 32'd1);
    end
    cyc(0, 2'b11, 2'b00, 0); check_eq("p4_block_b", 32'(obs_ready_b), 32'd0);
    cyc(0, 2'b11, 2'b00, 0); check_eq("p4_block_b", 32'(obs_ready_b), 32'd0);
    cyc(0, 2'b11, 2'b01, 0); check_eq("p4_read_b", 32'(obs_ready_b), 32'd0);
    cyc(0, 2'b11, 2'b00, 0); check_eq("p4_rr_b", 32'(obs_ready_b), 32'd2);

    // Protocol errors are sticky until reset.
    cyc(1, 2'b00, 2'b00, 0);
    cyc(0, 2'b00, 2'b10, 0); check_eq("p5_empty_read", 32'(err_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b00, 2'b00, 0); check_eq("p5_sticky", 32'(err_a), 32'd1);
    end
    cyc(1, 2'b00, 2'b00, 0); check_eq("p5_clear", 32'(err_a), 32'd0);
    cyc(0, 2'b11, 2'b00, 0);
    cyc(0, 2'b11, 2'b00, 0);
    cyc(0, 2'b00, 2'b11, 0); check_eq("p5_multihot", 32'(err_a), 32'd1);
    cyc(1, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 2'b00, 0);
    cyc(0, 2'b00, 2'b00, 1); check_eq("p5_full_write", 32'(err_a), 32'd1);

    // Reset while a write is pending.
    cyc(1, 2'b00, 2'b00, 0);
    cyc(0, 2'b11, 2'b00, 0); check_eq("p6_pending", 32'(wr_a), 32'd1);
    cyc(1, 2'b11, 2'b00, 0);
    check_eq("p6_rst_ready", 32'(obs_ready_a), 32'd0);
    check_eq("p6_rst_wr", 32'(wr_a), 32'd0);
    cyc(0, 2'b00, 2'b00, 0); check_eq("p6_idle_ready", 32'(obs_ready_a), 32'd0);
    cyc(0, 2'b11, 2'b00, 0); check_eq("p6_first", 32'(obs_ready_a), 32'd1);

    // Randomized traffic with mostly legal reads.
    cyc(1, 2'b00, 2'b00, 0);
    for (int i = 0; i < 400; i++) begin
      rd = 2'b00;
      if ($urandom_range(0, 59) == 0) begin
        rd = 2'($urandom);
      end else if ($urandom_range(0, 2) == 0) begin
        pick = int'($urandom_range(0, FLUX - 1));
        if (mcnt(0, pick) > 0 && mcnt(1, pick) > 0) rd = 2'b01 << pick;
      end
      cyc(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, 2'($urandom), rd,
          ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
